// File: rtl/seg_scan_driver_if.sv
// Load/ack and display-line bundle for seg_scan_driver.
interface seg_scan_driver_if;
  logic [15:0] Disp_Data;
  logic [3:0]  Disp_Dot;
  logic        Disp_Load;
  logic        Disp_Ack;
  logic [7:0]  Seg_Out;
  logic [3:0]  Dig_Out;

  modport master (output Disp_Data, Disp_Dot, Disp_Load,
                  input  Disp_Ack, Seg_Out, Dig_Out);
  modport slave  (input  Disp_Data, Disp_Dot, Disp_Load,
                  output Disp_Ack, Seg_Out, Dig_Out);
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-seg scanner with frame-synchronous double-buffered load.
// Optional leading-zero suppression via SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
  parameter int DIV_CNT   = 25000,
  parameter int BLANK_CYC = 16
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST,
  seg_scan_driver_if.slave disp
);
  localparam int CW = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
  localparam logic [CW-1:0] LAST  = CW'(DIV_CNT - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          tick, boundary;
  logic [15:0]   act_data, act_data_nxt, shd_data;
  logic [3:0]    act_dot, act_dot_nxt, shd_dot;
  logic          pending;
  logic [3:0]    nib;
  logic          blank, slot_blank;
  logic [7:0]    seg_nxt;
  logic [3:0]    dig_nxt;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Outputs are registered from next-state values so Seg_Out/Dig_Out
  // change on the same edge as the index they describe.
  always_comb begin
    tick         = (cnt == LAST);
    boundary     = tick && (idx == 2'd3);
    cnt_nxt      = tick ? '0 : cnt + 1'b1;
    idx_nxt      = tick ? idx + 2'd1 : idx;
    act_data_nxt = act_data;
    act_dot_nxt  = act_dot;
    if (boundary) begin
      if (disp.Disp_Load) begin
        act_data_nxt = disp.Disp_Data;
        act_dot_nxt  = disp.Disp_Dot;
      end else if (pending) begin
        act_data_nxt = shd_data;
        act_dot_nxt  = shd_dot;
      end
    end
    nib = act_data_nxt[{idx_nxt, 2'b00} +: 4];
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = 1'b0;
    case (idx_nxt)
      2'd3:    blank = (act_data_nxt[15:12] == 4'h0);
      2'd2:    blank = (act_data_nxt[15:8]  == 8'h00);
      2'd1:    blank = (act_data_nxt[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign slot_blank = 1'b0;
    end else begin : g_blank
      assign slot_blank = (cnt_nxt < BLANK);
    end
  endgenerate

  assign seg_nxt = {~act_dot_nxt[idx_nxt], blank ? 7'h7F : hex_seg(nib)};
  assign dig_nxt = slot_blank ? 4'hF : ~(4'b0001 << idx_nxt);

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      cnt           <= '0;
      idx           <= '0;
      act_data      <= '0;
      act_dot       <= '0;
      shd_data      <= '0;
      shd_dot       <= '0;
      pending       <= 1'b0;
      disp.Disp_Ack <= 1'b0;
      disp.Seg_Out  <= 8'hFF;
      disp.Dig_Out  <= 4'hF;
    end else begin
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      act_data     <= act_data_nxt;
      act_dot      <= act_dot_nxt;
      disp.Seg_Out <= seg_nxt;
      disp.Dig_Out <= dig_nxt;
      if (disp.Disp_Load) begin
        shd_data <= disp.Disp_Data;
        shd_dot  <= disp.Disp_Dot;
      end
      // A load coinciding with the boundary is applied directly, never queued.
      if (boundary) begin
        disp.Disp_Ack <= pending | disp.Disp_Load;
        pending       <= 1'b0;
      end else begin
        disp.Disp_Ack <= 1'b0;
        if (disp.Disp_Load) pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with DIV_CNT=4, BLANK_CYC=1.
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  logic mon_en = 1'b0;
  int   j = 0;
  int   errs = 0;
  int   checks = 0;
  logic pend = 1'b0;
  logic [19:0] cur = '0;
  logic [19:0] q[$];

  seg_scan_driver_if dif();

  seg_scan_driver #(.DIV_CNT(4), .BLANK_CYC(1)) dut (
    .Sys_CLK(clk),
    .Sys_RST(rst),
    .disp(dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [19:0] v, input int d);
    logic [3:0] n;
    logic [7:0] s;
    n = v[d*4 +: 4];
    case (n)
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
    endcase
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if ((d == 3 && v[15:12] == 0) || (d == 2 && v[15:8] == 0) || (d == 1 && v[15:4] == 0))
      s = 8'hFF;
`endif
    if (v[16+d]) s[7] = 1'b0;
    return s;
  endfunction

  always @(posedge clk) rst_q <= rst;

  // Monitor: tracks slot position from its own cycle count and checks every cycle.
  always @(negedge clk) begin
    logic [3:0] ed;
    int di;
    if (mon_en) begin
      if (rst_q) begin
        j = 0;
        q.delete();
        pend = 1'b0;
        cur = '0;
        chk("rst_seg", {24'h0, dif.Seg_Out}, 32'hFF);
        chk("rst_dig", {28'h0, dif.Dig_Out}, 32'hF);
        chk("rst_ack", {31'h0, dif.Disp_Ack}, 32'h0);
      end else begin
        j++;
        di = (j / 4) % 4;
        if (dif.Disp_Ack) begin
          chk("ack_phase", j % 16, 0);
          chk("ack_expected", {31'h0, q.size() != 0}, 32'h1);
          if (q.size() != 0) begin
            cur = q.pop_front();
            pend = 1'b0;
          end
          chk("ack_seg", {24'h0, dif.Seg_Out}, {24'h0, exp_seg(cur, 0)});
        end
        ed = (j % 4 == 0) ? 4'hF : ~(4'b0001 << di);
        chk("dig", {28'h0, dif.Dig_Out}, {28'h0, ed});
        if (dif.Dig_Out != 4'hF)
          chk("seg", {24'h0, dif.Seg_Out}, {24'h0, exp_seg(cur, di)});
      end
    end
  end

  task automatic wait_phase(input int p);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1;
      if ((j + 1) % 16 == p) found = 1'b1;
    end
    chk("phase_wait", {31'h0, found}, 32'h1);
  endtask

  task automatic load_at(input int p, input logic [15:0] d, input logic [3:0] dt);
    wait_phase(p);
    dif.Disp_Load = 1'b1;
    dif.Disp_Data = d;
    dif.Disp_Dot  = dt;
    if (pend) q[q.size()-1] = {dt, d};
    else q.push_back({dt, d});
    pend = 1'b1;
    @(posedge clk); #1;
    dif.Disp_Load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    dif.Disp_Load = 1'b0;
    dif.Disp_Data = '0;
    dif.Disp_Dot  = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(34);

    load_at(5, 16'h12AF, 4'b0100);
    idle(40);
    chk("q_empty_load", q.size(), 0);

    load_at(2, 16'h1111, 4'b0000);
    load_at(7, 16'h2222, 4'b0000);
    idle(40);
    chk("q_empty_dbl", q.size(), 0);

    load_at(15, 16'h0008, 4'b0000);
    idle(40);
    chk("q_empty_coin", q.size(), 0);

    load_at(3, 16'hBEEF, 4'b0000);
    wait_phase(9);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(40);
    chk("q_empty_rst", q.size(), 0);

    load_at(5, 16'h0050, 4'b0000);
    idle(40);
    chk("q_empty_lzb", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Drives a 4-digit multiplexed seven-segment display from a 16-bit hex value, scanning one digit per prescaler tick. It is the output-side counterpart to the key debouncer: keys come in through the debouncer, and values go out to the display through this block. A load handshake double-buffers new values and swaps them in only at frame boundaries, so the display never tears. Segment and digit lines are active-low for common-anode hardware.

## Interface
- DIV_CNT, 25000: Sys_CLK cycles per digit slot; legal range ≥ 2.
- BLANK_CYC, 16: cycles at the start of each slot with all digits off (anti-ghosting); 0 ≤ BLANK_CYC < DIV_CNT.
- Sys_CLK  in  1  system clock; sole clock.
- Sys_RST  in  1  synchronous, active-high reset.
- Disp_Data  in  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- Disp_Dot  in  4  decimal-point request per digit; 1 lights the dot.
- Disp_Load  in  1  1-cycle strobe that captures Disp_Data and Disp_Dot.
- Disp_Ack  out  1  1-cycle pulse when captured data becomes the displayed data.
- Seg_Out  out  8  active-low segments; bit0=a … bit6=g, bit7=dp.
- Dig_Out  out  4  active-low digit enables; bit n selects digit n.

## Operation
- Prescaler: counts 0 to DIV_CNT-1, then wraps. A tick occurs in the cycle where count == DIV_CNT-1.
- Digit index (2 bits) advances on each tick: 0→1→2→3→0.
- A frame boundary is the tick on which the index wraps from 3 to 0.
- Shadow registers:
  - Disp_Load high captures Disp_Data/Disp_Dot into the shadow and sets pending.
  - A second load while pending overwrites the shadow (last value wins) and produces only one ack.
- Apply:
  - On a frame boundary with pending=1, active ← shadow, pending ← 0, and Disp_Ack=1 on the following cycle.
  - If Disp_Load and the boundary coincide, the Disp_Data/Disp_Dot present on that cycle are applied directly and pending is left clear.
- Decode (active-low, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - dp lit clears bit7.
- Reset values (all take effect on the edge where Sys_RST=1):
  - Seg_Out=8'hFF, Dig_Out=4'hF, Disp_Ack=0.
  - Active and shadow registers 0, pending=0, index=0, prescaler=0.
- Sys_RST asserted mid-frame or mid-pending discards the pending load, and no ack is issued. Reset has priority over Disp_Load.

## Timing
- All outputs are registered.
- Tick on cycle T:
  - At edge T+1: index and Seg_Out update, Dig_Out=4'hF.
  - Dig_Out stays 4'hF for BLANK_CYC cycles, then becomes ~(1<<index) until the next tick.
  - With BLANK_CYC=0, Dig_Out switches directly at T+1.
- Slot length is exactly DIV_CNT cycles; frame length is 4·DIV_CNT cycles.
- Load-to-display latency:
  - Minimum 1 cycle (coincident with a boundary).
  - Maximum 4·DIV_CNT cycles.
- Disp_Ack is asserted in the cycle in which the new Seg_Out for digit 0 first appears.
- After reset release, the first tick is at count DIV_CNT-1. Digit 0 is displayed from the first cycle after reset, following BLANK_CYC blanking.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined: leading-zero suppression on the active value.
  - Digit 3 is blanked if nibble 3 = 0.
  - Digit 2 is blanked if nibbles 3 and 2 = 0.
  - Digit 1 is blanked if nibbles 3, 2 and 1 = 0.
  - Digit 0 is never blanked.
  - A blanked digit drives segment bits [6:0]=7'h7F; dp still follows Disp_Dot.
  - Dig_Out timing is unchanged.
- SEG_LEADING_ZERO_BLANK_EN undefined: every digit is decoded, including leading zeros.

## Test plan
All scenarios use DIV_CNT=4 and BLANK_CYC=1.
- Reset scan: release reset with no load.
  - Seg_Out=C0 on all digits.
  - Dig_Out sequence per slot: F,E,E,E for digit 0, then F,D,D,D, then F,B,B,B, then F,7,7,7, repeating every 16 cycles.
- Load/ack: Disp_Data=16'h12AF, Disp_Dot=4'b0100 mid-frame.
  - Disp_Ack pulses once at the next frame boundary.
  - Digits 0..3 show 8E, 88, 24 (dp on), F9.
- Double load: load 16'h1111, then load 16'h2222 before the boundary.
  - One ack.
  - Display shows A4 on all digits; 1111 is never displayed.
- Coincident load: Disp_Load on the boundary tick cycle with 16'h0008.
  - Ack on the next cycle; digit 0 = 80.
  - No second ack at the following boundary.
- Reset mid-op: load 16'hBEEF, then assert Sys_RST before the boundary.
  - No ack.
  - Outputs return to FF/F; display shows 0000 after release.
- Macro: with SEG_LEADING_ZERO_BLANK_EN defined, load 16'h0050.
  - Digits 3 and 2 show FF; digit 1 shows 92; digit 0 shows C0.
  - Without the macro, digits 3 and 2 show C0.
